vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares the single-port screen VRAM between the video fetch engine and the CPU, one access per ce_7mn slot.
- Video fetch always has priority. CPU writes pass through a small posted-write FIFO; CPU reads are single-outstanding.
- Sits between the video controller's fetch address/data path, the CPU memory decoder and the VRAM macro.

Parameters:
- WB_DEPTH, 4, posted-write FIFO depth in entries; power of two, 2..16.
- AW, 15, VRAM address width.

Ports:
- clk_sys  in  1  master clock
- reset  in  1  asynchronous, active-high reset
- ce_7mn  in  1  slot strobe; one VRAM access per asserted cycle
- vid_req  in  1  video wants this slot; sampled only when ce_7mn=1
- vid_addr  in  AW  video fetch address
- vid_data  out  8  video read data
- vid_valid  out  1  one-clk pulse: vid_data is valid
- cpu_wr  in  1  one-clk write request pulse
- cpu_wr_addr  in  AW  write address
- cpu_wr_data  in  8  write data
- wb_full  out  1  FIFO holds WB_DEPTH entries
- wb_overflow  out  1  sticky: a write was dropped; cleared by reset only
- cpu_rd  in  1  one-clk read request pulse
- cpu_rd_addr  in  AW  read address
- rd_busy  out  1  read outstanding
- cpu_rd_data  out  8  read data
- cpu_rd_valid  out  1  one-clk pulse: cpu_rd_data is valid
- mem_addr  out  AW  VRAM address (registered)
- mem_din  out  8  VRAM write data (registered)
- mem_we  out  1  VRAM write enable; 1 for exactly one slot
- mem_dout  in  8  VRAM read data; valid at the next slot after the address is issued

Behaviour:
- Reset values: all outputs 0, FIFO empty, no read pending, grant = IDLE.
- Slot arbitration happens on each clk with ce_7mn=1, in this priority order:
  1. vid_req=1 -> grant VID; mem_addr<=vid_addr, mem_we<=0.
  2. Else, FIFO not empty -> grant WR; pop the head entry, drive mem_addr/mem_din, mem_we<=1.
  3. Else, read pending -> grant RD; mem_addr<=rd_addr, mem_we<=0.
  4. Else -> grant IDLE, mem_we<=0.
- mem_we is deasserted at the next slot unless that slot is also a WR grant.
- Read capture happens at the slot following a grant:
  - VID grant: vid_data<=mem_dout, vid_valid pulses for 1 clk.
  - RD grant: cpu_rd_data<=mem_dout, cpu_rd_valid pulses, rd_busy<=0.
  - The capture is performed before the new grant is evaluated in the same cycle.
- Ordering: a read is never granted while the FIFO is non-empty, so reads always observe earlier writes.
- Video is never stalled. CPU latency is unbounded only if vid_req is held continuously. The display pattern leaves at least 4 of every 8 slots free.
- FIFO push on cpu_wr:
  - Accepted if count<WB_DEPTH, or if a pop occurs in the same clk.
  - Otherwise the write is dropped and wb_overflow<=1.
  - Pointers wrap modulo WB_DEPTH; count is log2(WB_DEPTH)+1 bits.
  - wb_full is the registered value of (count==WB_DEPTH).
- Read request on cpu_rd:
  - Ignored while rd_busy=1.
  - Otherwise latch rd_addr and set rd_busy<=1.
  - cpu_rd and cpu_wr in the same clk: the write is pushed first; the read then waits for it to drain.
- cpu_wr/cpu_rd arriving on a ce_7mn clk are registered that clk and are eligible from the next slot.
- Reset asserted mid-operation: FIFO contents discarded, pending read dropped with no cpu_rd_valid, mem_we forced 0 immediately (asynchronous).

Optional Feature:
- Macro: VRAM_ARB_WB_FWD_EN.
- Defined: on a cpu_rd whose address matches any FIFO entry, the youngest matching entry's data is returned.
  - cpu_rd_valid pulses on the next clk; no VRAM access; rd_busy never rises.
  - A non-matching read may be granted ahead of buffered writes (FIFO-empty rule waived).
- Not defined: no address compare logic; strict drain-before-read ordering as above.

Test Plan:
- FIFO drain: with vid_req=0, push writes (0x1800,0xAA), (0x1801,0x55) -> mem_we high on the next two slots with those address/data pairs, in order; FIFO empty afterwards.
- Video priority: vid_req=1 on every slot while 3 writes are buffered -> no mem_we. Drop vid_req -> the 3 writes retire on 3 consecutive slots. vid_valid pulses one slot after each VID grant with the mem_dout value.
- Overflow: 5 cpu_wr pulses with WB_DEPTH=4 and no pop between them -> wb_full=1, the 5th write is dropped, wb_overflow=1 until reset. A push in the same clk as a pop while full -> accepted, no overflow.
- Read ordering: write 0x4000->0x12, then immediately read 0x4000 -> RD granted only after the WR slot; cpu_rd_data=0x12 from the memory model.
- Reset mid-read: assert reset while rd_busy=1 and 2 writes are buffered -> mem_we=0 asynchronously, no cpu_rd_valid, FIFO empty, all outputs 0.
- Forwarding (macro defined): buffer a write 0x0100->0x77, then read 0x0100 -> cpu_rd_valid on the next clk with 0x77 and no RD grant.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port screen VRAM between the video fetch
// engine and the CPU, one access per ce_7mn slot. Video always wins the slot.
// CPU writes are posted through a small FIFO and CPU reads are single-outstanding.
// A read is only granted once the FIFO has drained, so it sees all earlier writes.
// Optional feature macro: VRAM_ARB_WB_FWD_EN. When it is defined, a CPU read that
// hits a buffered write is answered from the FIFO (youngest match) on the next clk.
module vram_arbiter #(
    parameter int WB_DEPTH = 4,
    parameter int AW       = 15
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ce_7mn,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [7:0]    vid_data,
    output logic          vid_valid,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_wr_addr,
    input  logic [7:0]    cpu_wr_data,
    output logic          wb_full,
    output logic          wb_overflow,
    input  logic          cpu_rd,
    input  logic [AW-1:0] cpu_rd_addr,
    output logic          rd_busy,
    output logic [7:0]    cpu_rd_data,
    output logic          cpu_rd_valid,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_din,
    output logic          mem_we,
    input  logic [7:0]    mem_dout
);

    localparam int          PW      = $clog2(WB_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(WB_DEPTH);

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_VID,
        GNT_WR,
        GNT_RD
    } grant_t;

    grant_t grant;
    grant_t grant_next;

    logic [AW-1:0] fifo_addr [WB_DEPTH];
    logic [7:0]    fifo_data [WB_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [PW:0]   count_next;

    logic [AW-1:0] rd_addr;
    logic          rd_waiting;
    logic          pop;
    logic          push_ok;
    logic          fwd_hit;
    logic [7:0]    fwd_data;

    // Pick this slot's owner; a read whose grant was issued last slot is being
    // captured now and must not be granted a second time.
    always_comb begin
        grant_next = grant;
        rd_waiting = rd_busy && (grant != GNT_RD);
        if (ce_7mn) begin
            if (vid_req) begin
                grant_next = GNT_VID;
            end else if (count != '0) begin
                grant_next = GNT_WR;
            end else if (rd_waiting) begin
                grant_next = GNT_RD;
            end else begin
                grant_next = GNT_IDLE;
            end
        end
    end

    // A pop frees a slot in the same clk, so a push into a full FIFO is still accepted then.
    always_comb begin
        pop        = ce_7mn && (grant_next == GNT_WR);
        push_ok    = cpu_wr && ((count != DEPTH_C) || pop);
        count_next = count;
        case ({push_ok, pop})
            2'b10:   count_next = count + (PW+1)'(1);
            2'b01:   count_next = count - (PW+1)'(1);
            default: count_next = count;
        endcase
    end

`ifdef VRAM_ARB_WB_FWD_EN
    logic [PW-1:0] fwd_idx;

    // Scan buffered writes oldest to youngest so the youngest match wins; a write
    // pushed in this same clk is younger still and overrides everything.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            fwd_idx = rd_ptr + PW'(i);
            if (((PW+1)'(i) < count) && (fifo_addr[fwd_idx] == cpu_rd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = fifo_data[fwd_idx];
            end
        end
        if (push_ok && (cpu_wr_addr == cpu_rd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = cpu_wr_data;
        end
    end
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    // Register the grant and drive the VRAM port; address and data hold between slots.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            grant    <= GNT_IDLE;
            mem_addr <= '0;
            mem_din  <= '0;
            mem_we   <= 1'b0;
        end else begin
            grant <= grant_next;
            if (ce_7mn) begin
                case (grant_next)
                    GNT_VID: begin
                        mem_addr <= vid_addr;
                        mem_we   <= 1'b0;
                    end
                    GNT_WR: begin
                        mem_addr <= fifo_addr[rd_ptr];
                        mem_din  <= fifo_data[rd_ptr];
                        mem_we   <= 1'b1;
                    end
                    GNT_RD: begin
                        mem_addr <= rd_addr;
                        mem_we   <= 1'b0;
                    end
                    default: begin
                        mem_we <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Posted-write storage; contents need no reset because count marks what is valid.
    always_ff @(posedge clk_sys) begin
        if (push_ok) begin
            fifo_addr[wr_ptr] <= cpu_wr_addr;
            fifo_data[wr_ptr] <= cpu_wr_data;
        end
    end

    // FIFO pointers, occupancy, full flag and the sticky overflow flag.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            wb_full     <= 1'b0;
            wb_overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (cpu_wr && !push_ok) begin
                wb_overflow <= 1'b1;
            end
            count   <= count_next;
            wb_full <= (count_next == DEPTH_C);
        end
    end

    // Capture read data one slot after its grant, and accept new CPU read requests.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            vid_data     <= '0;
            vid_valid    <= 1'b0;
            cpu_rd_data  <= '0;
            cpu_rd_valid <= 1'b0;
            rd_busy      <= 1'b0;
            rd_addr      <= '0;
        end else begin
            vid_valid    <= 1'b0;
            cpu_rd_valid <= 1'b0;
            if (ce_7mn && (grant == GNT_VID)) begin
                vid_data  <= mem_dout;
                vid_valid <= 1'b1;
            end
            if (ce_7mn && (grant == GNT_RD)) begin
                cpu_rd_data  <= mem_dout;
                cpu_rd_valid <= 1'b1;
                rd_busy      <= 1'b0;
            end
            if (cpu_rd && !rd_busy) begin
                if (fwd_hit) begin
                    cpu_rd_data  <= fwd_data;
                    cpu_rd_valid <= 1'b1;
                end else begin
                    rd_addr <= cpu_rd_addr;
                    rd_busy <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed scenarios plus randomized traffic for vram_arbiter,
// checked every clock against a queue-based reference model and a VRAM model.
module tb_vram_arbiter;

    localparam int WB_DEPTH = 4;
    localparam int AW       = 15;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          ce_7mn;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [7:0]    vid_data;
    logic          vid_valid;
    logic          cpu_wr;
    logic [AW-1:0] cpu_wr_addr;
    logic [7:0]    cpu_wr_data;
    logic          wb_full;
    logic          wb_overflow;
    logic          cpu_rd;
    logic [AW-1:0] cpu_rd_addr;
    logic          rd_busy;
    logic [7:0]    cpu_rd_data;
    logic          cpu_rd_valid;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic          mem_we;
    logic [7:0]    mem_dout;

    vram_arbiter #(
        .WB_DEPTH (WB_DEPTH),
        .AW       (AW)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .ce_7mn       (ce_7mn),
        .vid_req      (vid_req),
        .vid_addr     (vid_addr),
        .vid_data     (vid_data),
        .vid_valid    (vid_valid),
        .cpu_wr       (cpu_wr),
        .cpu_wr_addr  (cpu_wr_addr),
        .cpu_wr_data  (cpu_wr_data),
        .wb_full      (wb_full),
        .wb_overflow  (wb_overflow),
        .cpu_rd       (cpu_rd),
        .cpu_rd_addr  (cpu_rd_addr),
        .rd_busy      (rd_busy),
        .cpu_rd_data  (cpu_rd_data),
        .cpu_rd_valid (cpu_rd_valid),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_we       (mem_we),
        .mem_dout     (mem_dout)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [7:0] memInit(int i);
        return 8'(i * 37 + (i >> 7));
    endfunction

    // VRAM macro model: asynchronous read, write on any clk with mem_we high.
    logic [7:0] vram [0:(1<<AW)-1];
    logic       vram_ready = 1'b0;
    assign mem_dout = vram[mem_addr];

    always @(posedge clk_sys) begin
        if (!vram_ready) begin
            for (int i = 0; i < (1 << AW); i++) vram[i] <= memInit(i);
            vram_ready <= 1'b1;
        end else if (mem_we) begin
            vram[mem_addr] <= mem_din;
        end
    end

    // Reference model state.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    wr_t           wq[$];
    logic [7:0]    mmem [0:(1<<AW)-1];
    int            last_slot;
    logic          m_busy;
    logic [AW-1:0] m_rd_addr;
    logic          e_vid_valid, e_rd_valid, e_mem_we, e_wb_full, e_ovf;
    logic [7:0]    e_vid_data, e_rd_data, e_mem_din;
    logic [AW-1:0] e_mem_addr;

    int checks = 0;
    int passes = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, actual, expected, $time);
    endtask

    task automatic modelReset();
        wq.delete();
        last_slot   = 0;
        m_busy      = 1'b0;
        m_rd_addr   = '0;
        e_vid_valid = 1'b0;
        e_rd_valid  = 1'b0;
        e_mem_we    = 1'b0;
        e_wb_full   = 1'b0;
        e_ovf       = 1'b0;
        e_vid_data  = '0;
        e_rd_data   = '0;
        e_mem_din   = '0;
        e_mem_addr  = '0;
    endtask

    // One clock of the model; slot owners: 0 idle, 1 video, 2 write, 3 read.
    task automatic modelStep();
        logic busy_before;
        logic popped;
        logic pushed;
        logic hit;
        logic [7:0] hit_data;
        wr_t  snap[$];
        wr_t  w;
        if (reset) begin
            modelReset();
            return;
        end
        busy_before = m_busy;
        snap        = wq;
        popped      = 1'b0;
        pushed      = 1'b0;
        e_vid_valid = 1'b0;
        e_rd_valid  = 1'b0;
        if (ce_7mn) begin
            if (last_slot == 1) begin
                e_vid_data  = mmem[e_mem_addr];
                e_vid_valid = 1'b1;
            end
            if (last_slot == 3) begin
                e_rd_data  = mmem[e_mem_addr];
                e_rd_valid = 1'b1;
                m_busy     = 1'b0;
            end
            if (vid_req) begin
                last_slot  = 1;
                e_mem_addr = vid_addr;
                e_mem_we   = 1'b0;
            end else if (wq.size() > 0) begin
                w          = wq.pop_front();
                last_slot  = 2;
                e_mem_addr = w.addr;
                e_mem_din  = w.data;
                e_mem_we   = 1'b1;
                mmem[w.addr] = w.data;
                popped     = 1'b1;
            end else if (m_busy) begin
                last_slot  = 3;
                e_mem_addr = m_rd_addr;
                e_mem_we   = 1'b0;
            end else begin
                last_slot  = 0;
                e_mem_we   = 1'b0;
            end
        end
        if (cpu_wr) begin
            if (snap.size() < WB_DEPTH || popped) begin
                wq.push_back({cpu_wr_addr, cpu_wr_data});
                pushed = 1'b1;
            end else begin
                e_ovf = 1'b1;
            end
        end
        if (cpu_rd && !busy_before) begin
            hit      = 1'b0;
            hit_data = '0;
`ifdef VRAM_ARB_WB_FWD_EN
            if (pushed && cpu_wr_addr == cpu_rd_addr) begin
                hit      = 1'b1;
                hit_data = cpu_wr_data;
            end else begin
                for (int i = snap.size() - 1; i >= 0; i--) begin
                    if (!hit && snap[i].addr == cpu_rd_addr) begin
                        hit      = 1'b1;
                        hit_data = snap[i].data;
                    end
                end
            end
`endif
            if (hit) begin
                e_rd_valid = 1'b1;
                e_rd_data  = hit_data;
            end else begin
                m_busy    = 1'b1;
                m_rd_addr = cpu_rd_addr;
            end
        end
        e_wb_full = (wq.size() == WB_DEPTH);
    endtask

    task automatic compareAll();
        checkOutput("mem_we",       32'(mem_we),       32'(e_mem_we));
        checkOutput("mem_addr",     32'(mem_addr),     32'(e_mem_addr));
        checkOutput("mem_din",      32'(mem_din),      32'(e_mem_din));
        checkOutput("vid_valid",    32'(vid_valid),    32'(e_vid_valid));
        checkOutput("vid_data",     32'(vid_data),     32'(e_vid_data));
        checkOutput("cpu_rd_valid", 32'(cpu_rd_valid), 32'(e_rd_valid));
        checkOutput("cpu_rd_data",  32'(cpu_rd_data),  32'(e_rd_data));
        checkOutput("rd_busy",      32'(rd_busy),      32'(m_busy));
        checkOutput("wb_full",      32'(wb_full),      32'(e_wb_full));
        checkOutput("wb_overflow",  32'(wb_overflow),  32'(e_ovf));
    endtask

    // Drive one clock of inputs (from the negedge), update the model at the
    // posedge and compare everything at the following negedge.
    task automatic applyStimulus(input logic ce, input logic vreq, input logic [AW-1:0] vaddr,
                                 input logic wr, input logic [AW-1:0] waddr, input logic [7:0] wdata,
                                 input logic rd, input logic [AW-1:0] raddr);
        ce_7mn      = ce;
        vid_req     = vreq;
        vid_addr    = vaddr;
        cpu_wr      = wr;
        cpu_wr_addr = waddr;
        cpu_wr_data = wdata;
        cpu_rd      = rd;
        cpu_rd_addr = raddr;
        @(posedge clk_sys);
        modelStep();
        @(negedge clk_sys);
        compareAll();
    endtask

    task automatic slot(input logic vreq, input logic [AW-1:0] vaddr);
        applyStimulus(1'b1, vreq, vaddr, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic pushWrite(input logic [AW-1:0] waddr, input logic [7:0] wdata);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, waddr, wdata, 1'b0, '0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic       seen;
        logic [7:0] got;
        int         vid_mode;

        for (int i = 0; i < (1 << AW); i++) mmem[i] = memInit(i);
        modelReset();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 15'h0123, 1'b1, 15'h0001, 8'h01, 1'b1, 15'h0002);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0);

        $display("[TB] FIFO drain");
        pushWrite(15'h1800, 8'hAA);
        pushWrite(15'h1801, 8'h55);
        slot(1'b0, '0);
        checkOutput("drain0_we",   32'(mem_we),   32'd1);
        checkOutput("drain0_addr", 32'(mem_addr), 32'h1800);
        checkOutput("drain0_din",  32'(mem_din),  32'hAA);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
        slot(1'b0, '0);
        checkOutput("drain1_we",   32'(mem_we),   32'd1);
        checkOutput("drain1_addr", 32'(mem_addr), 32'h1801);
        checkOutput("drain1_din",  32'(mem_din),  32'h55);
        slot(1'b0, '0);
        checkOutput("drain_done_we", 32'(mem_we), 32'd0);

        $display("[TB] video priority");
        pushWrite(15'h0200, 8'h11);
        pushWrite(15'h0201, 8'h22);
        pushWrite(15'h0202, 8'h33);
        for (int i = 0; i < 5; i++) slot(1'b1, AW'(15'h2000 + i * 3));
        checkOutput("vid_hold_we", 32'(mem_we), 32'd0);
        for (int i = 0; i < 4; i++) slot(1'b0, '0);

        $display("[TB] overflow");
        for (int i = 0; i < 4; i++) pushWrite(AW'(15'h0300 + i), 8'(8'h40 + i));
        checkOutput("full_after4", 32'(wb_full),     32'd1);
        checkOutput("no_ovf_yet",  32'(wb_overflow), 32'd0);
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 15'h0304, 8'h44, 1'b0, '0);
        checkOutput("push_pop_ovf",  32'(wb_overflow), 32'd0);
        checkOutput("push_pop_full", 32'(wb_full),     32'd1);
        pushWrite(15'h0305, 8'h45);
        checkOutput("ovf_set", 32'(wb_overflow), 32'd1);
        for (int i = 0; i < 6; i++) slot(1'b0, '0);
        checkOutput("ovf_sticky", 32'(wb_overflow), 32'd1);

        $display("[TB] read ordering");
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 15'h4000, 8'h12, 1'b1, 15'h4000);
        seen = 1'b0;
        got  = '0;
        for (int k = 0; k < 12 && !seen; k++) begin
            if (cpu_rd_valid) begin
                seen = 1'b1;
                got  = cpu_rd_data;
            end else begin
                slot(1'b0, '0);
            end
        end
        checkOutput("rd_order_seen", 32'(seen), 32'd1);
        checkOutput("rd_order_data", 32'(got),  32'h12);

        $display("[TB] reset mid-read");
        pushWrite(15'h0500, 8'h01);
        pushWrite(15'h0501, 8'h02);
        pushWrite(15'h0502, 8'h03);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1, 15'h0042);
        slot(1'b0, '0);
        checkOutput("pre_reset_we",   32'(mem_we),  32'd1);
        checkOutput("pre_reset_busy", 32'(rd_busy), 32'd1);
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput("async_we",        32'(mem_we),       32'd0);
        checkOutput("async_addr",      32'(mem_addr),     32'd0);
        checkOutput("async_din",       32'(mem_din),      32'd0);
        checkOutput("async_busy",      32'(rd_busy),      32'd0);
        checkOutput("async_full",      32'(wb_full),      32'd0);
        checkOutput("async_ovf",       32'(wb_overflow),  32'd0);
        checkOutput("async_rd_valid",  32'(cpu_rd_valid), 32'd0);
        checkOutput("async_rd_data",   32'(cpu_rd_data),  32'd0);
        checkOutput("async_vid_valid", 32'(vid_valid),    32'd0);
        checkOutput("async_vid_data",  32'(vid_data),     32'd0);
        @(negedge clk_sys);
        slot(1'b0, '0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) slot(1'b0, '0);
        checkOutput("post_reset_we", 32'(mem_we), 32'd0);

`ifdef VRAM_ARB_WB_FWD_EN
        $display("[TB] forwarding");
        pushWrite(15'h0100, 8'h77);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1, 15'h0100);
        checkOutput("fwd_valid", 32'(cpu_rd_valid), 32'd1);
        checkOutput("fwd_data",  32'(cpu_rd_data),  32'h77);
        checkOutput("fwd_busy",  32'(rd_busy),      32'd0);
        for (int i = 0; i < 4; i++) slot(1'b0, '0);
`endif

        $display("[TB] random traffic");
        vid_mode = 0;
        for (int n = 0; n < 3000; n++) begin
            logic vr;
            if (n % 16 == 0) vid_mode = int'($urandom_range(0, 2));
            vr = (vid_mode == 2) ? 1'b1 : (vid_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            applyStimulus(1'($urandom_range(0, 1)), vr, AW'($urandom),
                          ($urandom_range(0, 3) == 0), AW'(15'h1800 + $urandom_range(0, 7)), 8'($urandom),
                          ($urandom_range(0, 6) == 0), AW'(15'h1800 + $urandom_range(0, 7)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
